demux_1_4_reg: RTL and testbench

Registered 1:4 stream demultiplexer: accepts one W-bit word per cycle on a valid/ready input and routes it to one of four output channels selected by `sel`. Each channel has a one-word holding register with its own valid/ready handshake, so a stalled consumer blocks only traffic addressed to it. Per-channel 8-bit transfer counters support debug and bench checking. It sits on the distribution side of a datapath whose collection side is the 4:1 mux.

---
 rtl/demux_1_4_reg.sv | 72 +++++++
 tb/tb_demux_1_4_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 stream demultiplexer. Each output channel has a one-word
// holding register with its own valid/ready handshake and an 8-bit pop counter.
module demux_1_4_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  input  logic         d_valid,
  output logic         d_ready,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   y_valid,
  input  logic [3:0]   y_ready,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic [7:0]   cnt2,
  output logic [7:0]   cnt3
);

  logic [W-1:0] y_r   [4];
  logic [7:0]   cnt_r [4];
  logic [3:0]   valid_r;
  logic [3:0]   push_s;
  logic [3:0]   pop_s;

  // The addressed channel can take a word if it is empty or is being drained now.
  assign d_ready = !rst & (!valid_r[sel] | y_ready[sel]);
  assign pop_s   = valid_r & y_ready;

  genvar i;
  for (i = 0; i < 4; i++) begin : g_ch
    assign push_s[i] = d_valid & d_ready & (sel == 2'(i));

    // Channel holding register: a push wins over a pop, so a full channel
    // with a ready consumer sustains one word per cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        y_r[i]     <= '0;
        valid_r[i] <= 1'b0;
      end else if (push_s[i]) begin
        y_r[i]     <= d;
        valid_r[i] <= 1'b1;
      end else if (pop_s[i]) begin
        valid_r[i] <= 1'b0;
      end
    end

    // Delivered-word counter, wraps modulo 256.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r[i] <= 8'd0;
      end else if (pop_s[i]) begin
        cnt_r[i] <= cnt_r[i] + 8'd1;
      end
    end
  end

  assign y0      = y_r[0];
  assign y1      = y_r[1];
  assign y2      = y_r[2];
  assign y3      = y_r[3];
  assign cnt0    = cnt_r[0];
  assign cnt1    = cnt_r[1];
  assign cnt2    = cnt_r[2];
  assign cnt3    = cnt_r[3];
  assign y_valid = valid_r;

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Scoreboard bench for demux_1_4_reg: per-channel queues of expected words,
// pushed on predicted input transfers and compared/popped on output transfers.
module tb_demux_1_4_reg;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic [1:0] sel;
  logic       d_valid;
  logic       d_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  logic [3:0] ya [4];
  logic [7:0] ca [4];
  logic [3:0] exp_q [4][$];
  logic [7:0] mcnt [4];
  logic       acc;
  int         n_chk;
  int         n_pass;

  demux_1_4_reg #(.W(4)) dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .d_valid(d_valid), .d_ready(d_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y_valid(y_valid), .y_ready(y_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  assign ya[0] = y0;
  assign ya[1] = y1;
  assign ya[2] = y2;
  assign ya[3] = y3;
  assign ca[0] = cnt0;
  assign ca[1] = cnt1;
  assign ca[2] = cnt2;
  assign ca[3] = cnt3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the scoreboard at the falling edge,
  // then advance the scoreboard by the transfers the current inputs imply.
  task automatic step();
    logic exp_rdy;
    logic pop_now [4];
    @(negedge clk);
    exp_rdy = !rst && (exp_q[sel].size() == 0 || y_ready[sel]);
    check("d_ready", {31'd0, d_ready}, {31'd0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("y_valid[%0d]", i), {31'd0, y_valid[i]}, {31'd0, exp_q[i].size() != 0});
      if (exp_q[i].size() != 0) begin
        check($sformatf("y%0d", i), {28'd0, ya[i]}, {28'd0, exp_q[i][0]});
      end
      check($sformatf("cnt%0d", i), {24'd0, ca[i]}, {24'd0, mcnt[i]});
    end
    acc = d_valid && exp_rdy;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        mcnt[i] = 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pop_now[i] = (exp_q[i].size() != 0) && y_ready[i];
        if (pop_now[i]) begin
          void'(exp_q[i].pop_front());
          mcnt[i] = mcnt[i] + 8'd1;
        end
      end
      if (acc) exp_q[sel].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    acc     = 1'b0;
    rst     = 1'b1;
    d       = 4'hF;
    sel     = 2'd0;
    d_valid = 1'b1;
    y_ready = 4'b0000;
    for (int i = 0; i < 4; i++) mcnt[i] = 8'd0;
    @(posedge clk);
    #1;

    // Reset with a word offered: nothing captured
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("reset_y", {28'd0, ya[i]}, 32'd0);
      check("reset_cnt", {24'd0, ca[i]}, 32'd0);
    end
    check("reset_valid", {28'd0, y_valid}, 32'd0);

    // Routing back-to-back to all four channels
    rst     = 1'b0;
    y_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      d   = 4'(s + 1);
      step();
    end
    d_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("route_y", {28'd0, ya[i]}, 32'(i + 1));
      check("route_cnt", {24'd0, ca[i]}, 32'd1);
    end

    // Back-pressure on channel 2
    y_ready = 4'b1011;
    sel     = 2'd2;
    d       = 4'hA;
    d_valid = 1'b1;
    step();
    d = 4'hB;
    step();
    check("bp_stall", {31'd0, d_ready}, 32'd0);
    step();
    check("bp_hold", {28'd0, y2}, 32'hA);
    y_ready = 4'b1111;
    step();
    check("bp_load", {28'd0, y2}, 32'hB);
    check("bp_cnt1", {24'd0, cnt2}, 32'd2);
    d_valid = 1'b0;
    step();
    check("bp_cnt2", {24'd0, cnt2}, 32'd3);

    // Isolation: stalled channel 1 does not block channel 3
    y_ready = 4'b1101;
    sel     = 2'd1;
    d       = 4'h7;
    d_valid = 1'b1;
    step();
    sel = 2'd3;
    d   = 4'h5;
    step();
    check("iso_y3", {28'd0, y3}, 32'h5);
    check("iso_y1", {28'd0, y1}, 32'h7);
    check("iso_v1", {31'd0, y_valid[1]}, 32'd1);
    d_valid = 1'b0;
    y_ready = 4'b1111;
    step();
    step();

    // Counter wrap: 257 pops on channel 0 from a clean reset
    rst = 1'b1;
    step();
    rst     = 1'b0;
    sel     = 2'd0;
    d_valid = 1'b1;
    for (int k = 0; k < 257; k++) begin
      d = 4'(k);
      step();
    end
    d_valid = 1'b0;
    step();
    check("wrap_cnt0", {24'd0, cnt0}, 32'd1);

    // Reset while all four channels are full
    y_ready = 4'b0000;
    d_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      d   = 4'(s + 8);
      step();
    end
    check("full_valid", {28'd0, y_valid}, 32'hF);
    d_valid = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    check("mid_valid", {28'd0, y_valid}, 32'd0);
    for (int i = 0; i < 4; i++) check("mid_cnt", {24'd0, ca[i]}, 32'd0);
    y_ready = 4'b1111;
    sel     = 2'd2;
    d       = 4'hC;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    step();
    check("resume_y2", {28'd0, y2}, 32'hC);
    check("resume_cnt2", {24'd0, cnt2}, 32'd1);

    // Random traffic obeying the producer hold rule
    d_valid = 1'b0;
    acc     = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!d_valid || acc) begin
        d_valid = ($urandom_range(0, 3) != 0);
        sel     = 2'($urandom_range(0, 3));
        d       = 4'($urandom_range(0, 15));
      end
      y_ready = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
